regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the CPU general-purpose register file. It has configurable data width and depth, one write port and two combinational read ports. Optional features are write-to-read bypass and a hardwired zero register. A sequential clear engine zeroes the array one entry per clock, so software-initiated clears need no wide single-edge reset fan-out. It sits between the decode/ALU stage and the writeback mux of the CPU datapath.

Parameters:
WIDTH, 16, data width of each register
DEPTH, 16, number of registers; power of two, minimum 2
AW, $clog2(DEPTH), register address width; derived, do not override
BYPASS, 1, when 1 a same-edge write is forwarded to the read ports
ZERO_REG, 0, when 1 register 0 always reads 0 and ignores writes

Ports:
C  input  1  clock; all state updates on falling edge of C (CPU writeback timing)
res  input  1  asynchronous active-high reset
Din  input  WIDTH  write data
we  input  1  write enable
Rw  input  AW  write address
Ra  input  AW  read address A
Rb  input  AW  read address B
Da  output  WIDTH  read data A (combinational)
Db  output  WIDTH  read data B (combinational)
clr  input  1  start sequential clear (sampled on falling edge)
busy  output  1  clear engine active; high in CLEAR state

Behaviour:
- Reset (res high, asynchronous):
  - all DEPTH registers go to 0, state goes to IDLE, clear counter goes to 0, busy goes to 0.
  - Da and Db therefore read 0.
  - Reset overrides we and clr and holds while res is high.
- Write in IDLE: on falling edge of C with we=1, mem[Rw] <= Din.
  - If ZERO_REG=1 and Rw=0, the write is dropped.
- Read:
  - Da = mem[Ra], Db = mem[Rb]; no clock involved.
  - If ZERO_REG=1 and address=0, output is 0.
  - If BYPASS=1, state IDLE, we=1 and Ra==Rw (Rw nonzero when ZERO_REG=1), Da=Din. Same rule for Db/Rb.
  - BYPASS=0: the new value is visible only after the falling edge.
- FSM states are IDLE and CLEAR.
  - IDLE with clr=1 at a falling edge: state<=CLEAR, cnt<=0. A simultaneous we in that cycle is still performed.
  - CLEAR, each falling edge: mem[cnt]<=0.
    - If cnt==DEPTH-1: state<=IDLE.
    - Otherwise cnt<=cnt+1.
  - busy = (state==CLEAR). It stays high for exactly DEPTH clock cycles, then falls on the edge that clears entry DEPTH-1.
- During CLEAR:
  - we is ignored and the write is lost; the issuing stage must stall on busy.
  - clr is ignored; a clear is not restarted or extended.
  - Bypass is disabled.
  - Reads return current array contents: entries below cnt read 0, entries at or above cnt read old values.
- Counter wrap: cnt never wraps. Exit is decided by the cnt==DEPTH-1 compare.
- Reset asserted mid-clear: immediate IDLE, all zeros, busy 0.
- Same-edge we and Rw in IDLE with Ra==Rb==Rw: both ports bypass identically.

Decomposition:
- Package regfile_pkg:
  - state enum {IDLE, CLEAR}
  - helper function for address width
  - constant CLR_LATENCY = DEPTH
- One sub-module, regfile_clear_seq:
  - FSM plus AW-bit counter
  - outputs busy, clr_we, clr_addr
- The array, write mux and bypass logic live in the top level.

Test Plan:
- Reset, then read all addresses -> Da=Db=0; busy=0.
- we=1, Rw=3, Din=16'hBEEF at edge; then Ra=3, Rb=3 -> Da=Db=16'hBEEF. With BYPASS=1, Da=16'hBEEF already in the cycle before the edge (Ra=3, we=1).
- ZERO_REG=1: write Rw=0, Din=16'h1234 -> Da(Ra=0)=0; a write to Rw=1 still works.
- Fill regs 0..15 with i+1, pulse clr for one edge -> busy high for exactly 16 cycles.
  - After the k-th CLEAR edge: regs 0..k-1 read 0, reg k reads k+1.
  - After 16 edges: all 0, busy=0.
- During CLEAR, we=1, Rw=15, Din=16'hFFFF, and a second clr pulse -> write dropped, reg 15 ends 0, busy length still 16.
- Assert res asynchronously between clock edges at cnt=5 during CLEAR -> busy drops immediately, all regs 0. A subsequent write to Rw=2 in IDLE succeeds.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_DEPTH   = 16;
  // Clear takes one falling edge per entry.
  localparam int CLR_LATENCY = DEF_DEPTH;

  // A 2-entry file still needs a 1-bit address.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int clr_latency(input int depth);
    return depth;
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Sequential clear engine: walks the array one entry per falling edge.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = addr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Exit on the compare, never on wrap, so the counter stays put after a clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
        else                         cnt_d   = cnt_q + AW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: 1 write port on falling edge, 2 combinational reads.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int AW       = addr_w(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             C,
  input  logic             res,
  input  logic [WIDTH-1:0] Din,
  input  logic             we,
  input  logic [AW-1:0]    Rw,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  output logic [WIDTH-1:0] Da,
  output logic [WIDTH-1:0] Db,
  input  logic             clr,
  output logic             busy
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic                        clr_we;
  logic [AW-1:0]               clr_addr;
  logic                        wr_ok, hit_a, hit_b, zr_a, zr_b;

  regfile_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_clr (
    .clk_i      (C),
    .rst_i      (res),
    .clr_i      (clr),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Writes are lost while clearing; the issuing stage stalls on busy.
  assign wr_ok = we && !busy && !((ZERO_REG != 0) && (Rw == '0));

  always_ff @(negedge C or posedge res) begin
    if (res)         mem_q           <= '0;
    else if (clr_we) mem_q[clr_addr] <= '0;
    else if (wr_ok)  mem_q[Rw]       <= Din;
  end

  assign hit_a = (BYPASS != 0) && wr_ok && (Ra == Rw);
  assign hit_b = (BYPASS != 0) && wr_ok && (Rb == Rw);
  assign zr_a  = (ZERO_REG != 0) && (Ra == '0);
  assign zr_b  = (ZERO_REG != 0) && (Rb == '0);

  assign Da = zr_a ? '0 : hit_a ? Din : mem_q[Ra];
  assign Db = zr_b ? '0 : hit_b ? Din : mem_q[Rb];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench: bypass/plain instance and zero-register instance side by side.
module tb_regfile_param;
  import regfile_pkg::*;

  logic        C, res, we, clr;
  logic [15:0] Din, Da, Db, Da_z, Db_z;
  logic [3:0]  Rw, Ra, Rb;
  logic        busy, busy_z;
  int          n_chk, n_fail;

  regfile_param #(.WIDTH(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(0)) u_dut (
    .C(C), .res(res), .Din(Din), .we(we), .Rw(Rw), .Ra(Ra), .Rb(Rb),
    .Da(Da), .Db(Db), .clr(clr), .busy(busy)
  );

  regfile_param #(.WIDTH(16), .DEPTH(16), .BYPASS(0), .ZERO_REG(1)) u_dut_z (
    .C(C), .res(res), .Din(Din), .we(we), .Rw(Rw), .Ra(Ra), .Rb(Rb),
    .Da(Da_z), .Db(Db_z), .clr(clr), .busy(busy_z)
  );

  initial C = 1'b1;
  always #5 C = ~C;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Return just after the active (falling) edge.
  task automatic step();
    @(negedge C);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; Rw = 4'(i); Din = 16'(i + 1);
      step();
    end
    we = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    res = 1'b1; we = 1'b0; clr = 1'b0; Din = '0; Rw = '0; Ra = '0; Rb = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_da", Da, 0);
    step();
    res = 1'b0;
    #1;
    for (int a = 0; a < 16; a++) begin
      Ra = 4'(a); Rb = 4'(15 - a);
      #1;
      chk("rst_rd_a", Da, 0);
      chk("rst_rd_b", Db, 0);
    end
    chk("rst_busy2", busy, 0);

    // Bypass: same-cycle forward on both ports; plain instance waits for the edge.
    we = 1'b1; Rw = 4'd3; Din = 16'hBEEF; Ra = 4'd3; Rb = 4'd3;
    #1;
    chk("byp_da", Da, 16'hBEEF);
    chk("byp_db", Db, 16'hBEEF);
    chk("nobyp_da", Da_z, 16'h0000);
    step();
    we = 1'b0;
    #1;
    chk("wr_da", Da, 16'hBEEF);
    chk("wr_db", Db, 16'hBEEF);
    chk("wr_da_z", Da_z, 16'hBEEF);

    // Hardwired zero register.
    we = 1'b1; Rw = 4'd0; Din = 16'h1234; Ra = 4'd0;
    #1;
    chk("zr_byp", Da_z, 16'h0000);
    step();
    we = 1'b0;
    #1;
    chk("zr_rd", Da_z, 16'h0000);
    chk("nz_rd0", Da, 16'h1234);
    we = 1'b1; Rw = 4'd1; Din = 16'h5678;
    step();
    we = 1'b0; Ra = 4'd1;
    #1;
    chk("zr_wr1", Da_z, 16'h5678);

    // Sequential clear with a dropped write and an ignored second clr.
    fill();
    Ra = 4'd7; Rb = 4'd15;
    #1;
    chk("fill_7", Da, 16'd8);
    chk("fill_15", Db, 16'd16);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_busy0", busy, 1);
    for (int k = 1; k <= CLR_LATENCY; k++) begin
      step();
      we = 1'b0; clr = 1'b0;
      Ra = 4'(k - 1); Rb = 4'(k % 16);
      #1;
      chk("clr_lo", Da, 0);
      if (k < CLR_LATENCY) begin
        chk("clr_hi", Db, 16'(k + 1));
        chk("clr_busy", busy, 1);
        chk("clr_busy_z", busy_z, 1);
      end else begin
        chk("clr_done", busy, 0);
      end
      if (k == 3) begin
        we = 1'b1; Rw = 4'd15; Din = 16'hFFFF; clr = 1'b1; Ra = 4'd15;
        #1;
        chk("clr_nobyp", Da, 16'd16);
      end
      if (k == 4) begin
        Ra = 4'd15;
        #1;
        chk("clr_wr_drop", Da, 16'd16);
      end
    end
    for (int a = 0; a < 16; a++) begin
      Ra = 4'(a);
      #1;
      chk("clr_all0", Da, 0);
    end
    step();
    chk("clr_norestart", busy, 0);

    // Asynchronous reset mid-clear at cnt=5.
    fill();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid_busy", busy, 1);
    #2;
    res = 1'b1;
    #1;
    chk("ares_busy", busy, 0);
    Ra = 4'd10; Rb = 4'd15;
    #1;
    chk("ares_da", Da, 0);
    chk("ares_db", Db, 0);
    res = 1'b0;
    step();
    chk("ares_idle", busy, 0);
    we = 1'b1; Rw = 4'd2; Din = 16'hABCD;
    step();
    we = 1'b0; Ra = 4'd2; Rb = 4'd3;
    #1;
    chk("post_wr", Da, 16'hABCD);
    chk("post_rb", Db, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
